// File: rtl/ram_loader_pkg.sv
// ram_loader_pkg: shared definitions for the program-RAM loader.
//   ADDR_W_DEF / DATA_W_DEF / DEPTH_DEF : default geometry of the 16x8 RAM
//   state_e                             : loader FSM states
package ram_loader_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FILL  = 3'd2,
    CKSUM = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/ram_loader_if.sv
// ram_loader_if: valid/ready byte stream carrying a program image.
//   s_valid  source -> loader  byte valid
//   s_ready  loader -> source  byte accepted this cycle
//   s_data   source -> loader  stream byte
//   s_last   source -> loader  final byte of the image
//   modport master : stream source
//   modport slave  : loader side
interface ram_loader_if
  import ram_loader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);

endinterface

// File: rtl/ram_loader.sv
// ram_loader: writer side of the program RAM. Takes a byte stream, writes it
// to addresses 0..DEPTH-1 (zero-filling after an early s_last) and holds the
// uC in clear until the image is complete.
// Ports:
//   clk        rising-edge clock
//   clr        asynchronous active-low reset
//   start      1-cycle pulse, begins a load from IDLE or DONE
//   s          ram_loader_if.slave byte stream (s_valid/s_ready/s_data/s_last)
//   prog_we    RAM write strobe, one cycle per word
//   prog_addr  RAM write address
//   prog_data  RAM write data
//   cpu_hold   1 = uC held in clear, RAM owned by loader
//   done       image loaded, uC released
//   err        checksum mismatch, sticky until next start
// Build option: define LOADER_CHECKSUM_EN to require one extra checksum byte
// (sum of the 16 stored words mod 256) after the image; otherwise err is 0.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  ram_loader_if.slave       s,
  output logic              prog_we,
  output logic [ADDR_W-1:0] prog_addr,
  output logic [DATA_W-1:0] prog_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

`ifdef LOADER_CHECKSUM_EN
  localparam state_e IMG_END = CKSUM;
`else
  localparam state_e IMG_END = DONE;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              s_ready_q, s_ready_d;
  logic              prog_we_q, prog_we_d;
  logic [ADDR_W-1:0] prog_addr_q, prog_addr_d;
  logic [DATA_W-1:0] prog_data_q, prog_data_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              done_q, done_d;
  logic              beat;
  logic              last_word;
  logic              load_start;
`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              err_q, err_d;
  logic              cksum_bad;
`endif

  assign beat      = s.s_valid && s_ready_q;
  assign last_word = (count_q == LAST_IDX);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    prog_we_d   = 1'b0;
    prog_addr_d = prog_addr_q;
    prog_data_d = prog_data_q;
    cpu_hold_d  = 1'b1;
    done_d      = 1'b0;
    load_start  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    cksum_bad   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = LOAD;
          count_d    = '0;
          load_start = 1'b1;
        end
      end
      LOAD: begin
        if (beat) begin
          prog_we_d   = 1'b1;
          prog_addr_d = count_q[ADDR_W-1:0];
          prog_data_d = s.s_data;
          count_d     = count_q + 1'b1;
          // The final slot ends the image whatever s_last says.
          if (last_word)     state_d = IMG_END;
          else if (s.s_last) state_d = FILL;
        end
      end
      FILL: begin
        prog_we_d   = 1'b1;
        prog_addr_d = count_q[ADDR_W-1:0];
        prog_data_d = '0;
        count_d     = count_q + 1'b1;
        if (last_word) state_d = IMG_END;
      end
`ifdef LOADER_CHECKSUM_EN
      CKSUM: begin
        if (beat) begin
          if (s.s_data == sum_q) begin
            state_d = DONE;
          end else begin
            state_d   = IDLE;
            cksum_bad = 1'b1;
          end
        end
      end
`endif
      DONE: begin
        if (start) begin
          state_d    = LOAD;
          count_d    = '0;
          load_start = 1'b1;
        end else begin
          cpu_hold_d = 1'b0;
          done_d     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Registered ready follows the state being entered, so it is high
    // exactly while the FSM sits in a byte-accepting state.
    s_ready_d = (state_d == LOAD) || (state_d == CKSUM);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= IDLE;
      count_q     <= '0;
      s_ready_q   <= 1'b0;
      prog_we_q   <= 1'b0;
      prog_addr_q <= '0;
      prog_data_q <= '0;
      cpu_hold_q  <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      s_ready_q   <= s_ready_d;
      prog_we_q   <= prog_we_d;
      prog_addr_q <= prog_addr_d;
      prog_data_q <= prog_data_d;
      cpu_hold_q  <= cpu_hold_d;
      done_q      <= done_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Fill zeros add nothing, so only stream beats in LOAD touch the sum.
  always_comb begin
    sum_d = sum_q;
    err_d = err_q;
    if (load_start) begin
      sum_d = '0;
      err_d = 1'b0;
    end else if (state_q == LOAD && beat) begin
      sum_d = sum_q + s.s_data;
    end
    if (cksum_bad) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sum_q <= '0;
      err_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign s.s_ready = s_ready_q;
  assign prog_we   = prog_we_q;
  assign prog_addr = prog_addr_q;
  assign prog_data = prog_data_q;
  assign cpu_hold  = cpu_hold_q;
  assign done      = done_q;

endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: scoreboard bench for ram_loader. Expected RAM writes are
// queued as bytes are driven and compared against the writes observed on
// prog_* once the load completes.
module tb_ram_loader;
  import ram_loader_pkg::*;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              clr = 1'b0;
  logic              start = 1'b0;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic              cpu_hold;
  logic              done;
  logic              err;

  ram_loader_if #(.DATA_W(DATA_W)) sif ();

  ram_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .s         (sif),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  logic [11:0] exp_q[$];
  logic [11:0] obs_q[$];
  int cyc = 0;
  int last_we_cyc = 0;
  logic [7:0] img_sum;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (clr && prog_we) begin
      obs_q.push_back({prog_addr, prog_data});
      last_we_cyc = cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last, input bit gap);
    int n;
    if (gap) begin
      sif.s_valid = 1'b0;
      step();
    end
    sif.s_valid = 1'b1;
    sif.s_data  = d;
    sif.s_last  = last;
    n = 0;
    @(negedge clk);
    while (sif.s_ready !== 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    total++;
    if (sif.s_ready !== 1'b1)
      $display("FAIL beat_accept: s_ready=%b required 1 for byte %h", sif.s_ready, d);
    else
      passed++;
    step();
    sif.s_valid = 1'b0;
    sif.s_last  = 1'b0;
  endtask

  task automatic load_image(input logic [7:0] base, input logic [7:0] incr,
                            input int len, input bit gap, input bit with_last);
    logic [7:0] d;
    img_sum = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      d = (i < len) ? base + incr * 8'(i) : 8'h00;
      exp_q.push_back({4'(i), d});
      img_sum += d;
      if (i < len) send_byte(d, with_last && (i == len - 1), gap);
    end
  endtask

  task automatic finish_image();
`ifdef LOADER_CHECKSUM_EN
    send_byte(img_sum, 1'b0, 1'b0);
`endif
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while (done !== 1'b1 && n < 60) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    clr = 1'b0;
    repeat (2) @(negedge clk);
    total += 7;
    if (cpu_hold !== 1'b1) $display("FAIL rst_cpu_hold: got %b required 1", cpu_hold); else passed++;
    if (done !== 1'b0) $display("FAIL rst_done: got %b required 0", done); else passed++;
    if (err !== 1'b0) $display("FAIL rst_err: got %b required 0", err); else passed++;
    if (prog_we !== 1'b0) $display("FAIL rst_prog_we: got %b required 0", prog_we); else passed++;
    if (prog_addr !== 4'h0) $display("FAIL rst_prog_addr: got %h required 0", prog_addr); else passed++;
    if (prog_data !== 8'h00) $display("FAIL rst_prog_data: got %h required 00", prog_data); else passed++;
    if (sif.s_ready !== 1'b0) $display("FAIL rst_s_ready: got %b required 0", sif.s_ready); else passed++;
    #2 clr = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    logic [11:0] e, o;
    obs_q.delete();
    exp_q.delete();
    pulse_start();
    @(negedge clk);
    total += 3;
    if (cpu_hold !== 1'b1) $display("FAIL b2b_hold_in_load: got %b required 1", cpu_hold); else passed++;
    if (done !== 1'b0) $display("FAIL b2b_done_in_load: got %b required 0", done); else passed++;
    if (sif.s_ready !== 1'b1) $display("FAIL b2b_ready_in_load: got %b required 1", sif.s_ready); else passed++;
    step();
    load_image(8'h10, 8'h01, 16, 1'b0, 1'b1);
    finish_image();
    wait_done();
    total += 3;
    if (done !== 1'b1) $display("FAIL b2b_done: got %b required 1", done); else passed++;
    if (cpu_hold !== 1'b0) $display("FAIL b2b_cpu_hold: got %b required 0", cpu_hold); else passed++;
    if (err !== 1'b0) $display("FAIL b2b_err: got %b required 0", err); else passed++;
`ifndef LOADER_CHECKSUM_EN
    total++;
    if (cyc - last_we_cyc != 1)
      $display("FAIL b2b_done_latency: got %0d cycles after last strobe required 1", cyc - last_we_cyc);
    else passed++;
`endif
    step();
    total++;
    if (obs_q.size() != 16) $display("FAIL b2b_write_count: got %0d required 16", obs_q.size()); else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 12'hxxx;
      total++;
      if (o !== e) $display("FAIL b2b_write: got addr/data %h required %h", o, e); else passed++;
    end
  endtask

  task automatic test_overflow();
    obs_q.delete();
    sif.s_valid = 1'b1;
    sif.s_data  = 8'h99;
    sif.s_last  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total += 2;
      if (sif.s_ready !== 1'b0) $display("FAIL ovf_ready: got %b required 0", sif.s_ready); else passed++;
      if (done !== 1'b1) $display("FAIL ovf_done: got %b required 1", done); else passed++;
    end
    step();
    sif.s_valid = 1'b0;
    sif.s_last  = 1'b0;
    total++;
    if (obs_q.size() != 0) $display("FAIL ovf_extra_write: got %0d writes required 0", obs_q.size()); else passed++;
  endtask

  task automatic test_toggle_valid();
    logic [11:0] e, o;
    obs_q.delete();
    exp_q.delete();
    pulse_start();
    @(negedge clk);
    total += 2;
    if (cpu_hold !== 1'b1) $display("FAIL restart_cpu_hold: got %b required 1", cpu_hold); else passed++;
    if (done !== 1'b0) $display("FAIL restart_done: got %b required 0", done); else passed++;
    step();
    load_image(8'h20, 8'h01, 16, 1'b1, 1'b1);
    finish_image();
    wait_done();
    total++;
    if (done !== 1'b1) $display("FAIL tog_done: got %b required 1", done); else passed++;
    step();
    total++;
    if (obs_q.size() != 16) $display("FAIL tog_write_count: got %0d required 16", obs_q.size()); else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 12'hxxx;
      total++;
      if (o !== e) $display("FAIL tog_write: got addr/data %h required %h", o, e); else passed++;
    end
  endtask

  task automatic test_short();
    logic [11:0] e, o;
    obs_q.delete();
    exp_q.delete();
    pulse_start();
    load_image(8'hA1, 8'h01, 3, 1'b0, 1'b1);
    finish_image();
    wait_done();
    total += 2;
    if (done !== 1'b1) $display("FAIL short_done: got %b required 1", done); else passed++;
    if (cpu_hold !== 1'b0) $display("FAIL short_cpu_hold: got %b required 0", cpu_hold); else passed++;
    step();
    total++;
    if (obs_q.size() != 16) $display("FAIL short_write_count: got %0d required 16", obs_q.size()); else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 12'hxxx;
      total++;
      if (o !== e) $display("FAIL short_write: got addr/data %h required %h", o, e); else passed++;
    end
  endtask

  task automatic test_abort();
    logic [11:0] e, o;
    obs_q.delete();
    exp_q.delete();
    pulse_start();
    load_image(8'h60, 8'h01, 5, 1'b0, 1'b0);
    clr = 1'b0;
    #1;
    total += 4;
    if (cpu_hold !== 1'b1) $display("FAIL abort_cpu_hold: got %b required 1", cpu_hold); else passed++;
    if (done !== 1'b0) $display("FAIL abort_done: got %b required 0", done); else passed++;
    if (prog_we !== 1'b0) $display("FAIL abort_prog_we: got %b required 0", prog_we); else passed++;
    if (sif.s_ready !== 1'b0) $display("FAIL abort_s_ready: got %b required 0", sif.s_ready); else passed++;
    #2 clr = 1'b1;
    step();
    obs_q.delete();
    exp_q.delete();
    pulse_start();
    load_image(8'h70, 8'h03, 16, 1'b0, 1'b1);
    finish_image();
    wait_done();
    total++;
    if (done !== 1'b1) $display("FAIL reload_done: got %b required 1", done); else passed++;
    step();
    total++;
    if (obs_q.size() != 16) $display("FAIL reload_write_count: got %0d required 16", obs_q.size()); else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 12'hxxx;
      total++;
      if (o !== e) $display("FAIL reload_write: got addr/data %h required %h", o, e); else passed++;
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    pulse_start();
    load_image(8'h01, 8'h00, 16, 1'b0, 1'b1);
    send_byte(8'h10, 1'b0, 1'b0);
    wait_done();
    total += 2;
    if (done !== 1'b1) $display("FAIL cks_good_done: got %b required 1", done); else passed++;
    if (err !== 1'b0) $display("FAIL cks_good_err: got %b required 0", err); else passed++;
    step();
    pulse_start();
    load_image(8'h01, 8'h00, 16, 1'b0, 1'b1);
    send_byte(8'h11, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    total += 4;
    if (err !== 1'b1) $display("FAIL cks_bad_err: got %b required 1", err); else passed++;
    if (cpu_hold !== 1'b1) $display("FAIL cks_bad_cpu_hold: got %b required 1", cpu_hold); else passed++;
    if (done !== 1'b0) $display("FAIL cks_bad_done: got %b required 0", done); else passed++;
    if (sif.s_ready !== 1'b0) $display("FAIL cks_bad_idle_ready: got %b required 0", sif.s_ready); else passed++;
    step();
    exp_q.delete();
    obs_q.delete();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sif.s_valid = 1'b0;
    sif.s_data  = 8'h00;
    sif.s_last  = 1'b0;
    test_reset();
    test_back_to_back();
`ifndef LOADER_CHECKSUM_EN
    test_overflow();
`endif
    test_toggle_valid();
    test_short();
    test_abort();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
